adc_window_scheduler: RTL and testbench
=======================================

# adc_window_scheduler

Sequences the LTC2320-16 acquisition front end (`adcControl`) in the 8-channel ADC design. It opens timed measurement windows by driving `adcControl`'s `PERFORM` input, separated by idle gaps. Over each window it collects the eight per-channel max flags into a sticky status word and saturating hit counts. Each window's result goes to the host through a valid/ack handshake.

## Interface
Parameters:
- `WINDOW_CYCLES`, default 2000000: `CLK` cycles `PERFORM` is held high per window (20 ms at 100 MHz); minimum 2.
- `GAP_CYCLES`, default 2000000: `CLK` cycles `PERFORM` is held low between windows; minimum 1.

Ports:
- `CLK` in 1: single clock, shared with `adcControl`.
- `RST` in 1: synchronous, active-high reset.
- `START` in 1: one-cycle request to begin a run; ignored while `BUSY`.
- `STOP` in 1: one-cycle request to end a continuous or multi-window run.
- `WINDOWS` in 8: number of windows per run, sampled on accepted `START`; 0 means continuous.
- `MAX_IN` in 8: `{ch8Max..ch1Max}` from `adcControl`, synchronous to `CLK`.
- `PERFORM` out 1: drives `adcControl.PERFORM`.
- `RESULT` out 8: sticky OR of `MAX_IN` over the last completed window.
- `HITS` out 64: eight 8-bit saturating rising-edge counts; channel k is at `[8k+7:8k]`, with k=0 for ch1.
- `RESULT_VALID` out 1: `RESULT`/`HITS` hold an unacknowledged window result.
- `RESULT_ACK` in 1: consumes the result when `RESULT_VALID` is high.
- `BUSY` out 1: high in any state other than IDLE.
- `OVERRUN` out 1: sticky; set when a result is overwritten before it was acked.

## Operation
- States: IDLE, WINDOW, GAP.
- **IDLE**
  - `PERFORM`=0, `BUSY`=0.
  - On `START`: load `remaining`=`WINDOWS`, clear `OVERRUN`, clear the stop latch, clear the internal accumulators and edge-history register, then go to WINDOW.
  - `STOP` is ignored in IDLE. If `START` and `STOP` arrive in the same cycle, the run starts.
- **WINDOW**
  - `PERFORM`=1 for exactly `WINDOW_CYCLES` cycles, timed by a down-counter.
  - Every cycle: `acc_flag` |= `MAX_IN`. For each bit with `MAX_IN`=1 and previous sample 0, increment that channel's count; counts saturate at 255.
  - The edge history is cleared on window entry, so a flag already high in the first window cycle counts as one hit.
  - On the final window cycle (its `MAX_IN` sample included): copy the accumulators to `RESULT`/`HITS`, set `RESULT_VALID`, clear the accumulators and history, then go to GAP.
- **GAP**
  - `PERFORM`=0 for `GAP_CYCLES` cycles; `MAX_IN` is not sampled.
  - At gap end:
    - If the stop latch is set, or `WINDOWS`≠0 and `remaining`=1, go to IDLE.
    - Otherwise decrement `remaining` (when `WINDOWS`≠0) and go to WINDOW.
- **STOP** during WINDOW or GAP sets the stop latch. The current window and its gap always complete; no window is truncated.
- **Handshake**
  - `RESULT_ACK` while `RESULT_VALID`=1 clears `RESULT_VALID` on the next edge.
  - `RESULT_ACK` while `RESULT_VALID`=0 is ignored.
  - If a publish occurs while `RESULT_VALID`=1 and no ack arrives in that cycle: overwrite the result and set `OVERRUN`.
  - If a publish and an ack occur in the same cycle: the publish wins, `RESULT_VALID` stays 1, and `OVERRUN` is not set.
- **Reset**: state=IDLE. All outputs are 0, including `PERFORM`, `RESULT`, `HITS`, `RESULT_VALID`, `BUSY` and `OVERRUN`. All counters, accumulators and latches are 0.
- Reset mid-run aborts immediately; no partial result is published.

## Timing
- All outputs are registered.
- `START` sampled at edge t: `PERFORM` and `BUSY` are high from t+1.
- `PERFORM` is high for exactly `WINDOW_CYCLES` cycles.
- `RESULT_VALID` rises in the same cycle `PERFORM` falls, which is the first GAP cycle.
- Window period = `WINDOW_CYCLES`+`GAP_CYCLES`.
- `BUSY` falls on the cycle after the last GAP cycle of the final window.
- Result fields are stable while `RESULT_VALID`=1 until the next publish.
- `RST` asserted at edge t: all outputs are 0 from t+1.

## Test plan
All scenarios use `WINDOW_CYCLES`=8, `GAP_CYCLES`=4 unless noted.
- **Single idle window.** Reset, then `START` with `WINDOWS`=1 and `MAX_IN`=0. Required: `PERFORM` high 8 cycles, then `RESULT_VALID`=1 with `RESULT`=0x00 and `HITS`=0. `BUSY` low 4 cycles after `PERFORM` falls.
- **Flag accumulation.** `WINDOWS`=1; `MAX_IN[2]` pulses 3 times (1-cycle pulses); `MAX_IN[7]` is high for the whole window, including the first cycle. Required: `RESULT`=0x84, `HITS[23:16]`=3, `HITS[63:56]`=1, all other counts 0.
- **Saturation.** `WINDOW_CYCLES`=600; `MAX_IN[0]` toggles every cycle, giving 300 rising edges. Required: `HITS[7:0]`=255 and `RESULT[0]`=1.
- **Continuous run with stop and overrun.** `WINDOWS`=0, no acks; `STOP` pulsed in cycle 3 of the third window. Required: exactly 3 `PERFORM` pulses of 8 cycles each; `OVERRUN`=1 from the second publish; `BUSY` drops after the third gap.
- **Handshake corners.** `RESULT_ACK` held high across the publish cycle. Required: `RESULT_VALID` stays 1 and `OVERRUN` stays 0. A further ack with `RESULT_VALID`=0 changes nothing.
- **Reset mid-window.** `RST` asserted in cycle 5 of a window. Required: next cycle `PERFORM`=0, `BUSY`=0, `RESULT_VALID`=0, `HITS`=0; `START` ignored while `RST` is high.

Source files
------------

// File: rtl/adc_window_scheduler.sv
// Opens timed PERFORM windows for the ADC front end, separated by idle gaps,
// and publishes per-window sticky max flags and saturating hit counts.
module adc_window_scheduler #(
  parameter int unsigned WINDOW_CYCLES = 2000000,
  parameter int unsigned GAP_CYCLES    = 2000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STOP,
  input  logic [7:0]  WINDOWS,
  input  logic [7:0]  MAX_IN,
  output logic        PERFORM,
  output logic [7:0]  RESULT,
  output logic [63:0] HITS,
  output logic        RESULT_VALID,
  input  logic        RESULT_ACK,
  output logic        BUSY,
  output logic        OVERRUN
);

  localparam int unsigned MAX_CYCLES = (WINDOW_CYCLES > GAP_CYCLES) ? WINDOW_CYCLES : GAP_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WINDOW, S_GAP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   timer_q, timer_d;
  logic [7:0]      remaining_q, remaining_d;
  logic [7:0]      windows_q, windows_d;
  logic            stop_q, stop_d;
  logic [7:0]      hist_q, hist_d;
  logic [7:0]      acc_flag_q, acc_flag_d;
  logic [7:0][7:0] acc_cnt_q, acc_cnt_d;
  logic            perform_q, perform_d;
  logic            busy_q, busy_d;
  logic [7:0]      result_q, result_d;
  logic [7:0][7:0] hits_q, hits_d;
  logic            valid_q, valid_d;
  logic            overrun_q, overrun_d;

  logic [7:0]      rise;
  logic [7:0]      flag_inc;
  logic [7:0][7:0] cnt_inc;
  logic            publish;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    timer_d     = timer_q;
    remaining_d = remaining_q;
    windows_d   = windows_q;
    stop_d      = stop_q;
    hist_d      = hist_q;
    acc_flag_d  = acc_flag_q;
    acc_cnt_d   = acc_cnt_q;
    result_d    = result_q;
    hits_d      = hits_q;
    valid_d     = valid_q;
    overrun_d   = overrun_q;
    publish     = 1'b0;

    // This cycle's sample folded into the accumulators, saturating at 255.
    rise     = MAX_IN & ~hist_q;
    flag_inc = acc_flag_q | MAX_IN;
    for (int k = 0; k < 8; k++) begin
      cnt_inc[k] = (rise[k] && acc_cnt_q[k] != 8'hFF) ? acc_cnt_q[k] + 8'd1 : acc_cnt_q[k];
    end

    case (state_q)
      S_IDLE: begin
        if (START) begin
          state_d     = S_WINDOW;
          timer_d     = CW'(WINDOW_CYCLES - 1);
          remaining_d = WINDOWS;
          windows_d   = WINDOWS;
          stop_d      = 1'b0;
          overrun_d   = 1'b0;
          hist_d      = '0;
          acc_flag_d  = '0;
          acc_cnt_d   = '0;
        end
      end
      S_WINDOW: begin
        if (STOP) stop_d = 1'b1;
        acc_flag_d = flag_inc;
        acc_cnt_d  = cnt_inc;
        hist_d     = MAX_IN;
        if (timer_q == '0) begin
          publish    = 1'b1;
          state_d    = S_GAP;
          timer_d    = CW'(GAP_CYCLES - 1);
          acc_flag_d = '0;
          acc_cnt_d  = '0;
          hist_d     = '0;
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      S_GAP: begin
        if (STOP) stop_d = 1'b1;
        if (timer_q == '0) begin
          if (stop_q || STOP || (windows_q != 8'd0 && remaining_q == 8'd1)) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_WINDOW;
            timer_d = CW'(WINDOW_CYCLES - 1);
            if (windows_q != 8'd0) remaining_d = remaining_q - 8'd1;
          end
        end else begin
          timer_d = timer_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A publish beats a same-cycle ack; overrun only when an unacked result is lost.
    if (publish) begin
      result_d = flag_inc;
      hits_d   = cnt_inc;
      valid_d  = 1'b1;
      if (valid_q && !RESULT_ACK) overrun_d = 1'b1;
    end else if (RESULT_ACK && valid_q) begin
      valid_d = 1'b0;
    end

    perform_d = (state_d == S_WINDOW);
    busy_d    = (state_d != S_IDLE);
  end

  // NOTE: state is updated only with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      remaining_q <= '0;
      windows_q   <= '0;
      stop_q      <= 1'b0;
      hist_q      <= '0;
      acc_flag_q  <= '0;
      acc_cnt_q   <= '0;
      perform_q   <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      hits_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      remaining_q <= remaining_d;
      windows_q   <= windows_d;
      stop_q      <= stop_d;
      hist_q      <= hist_d;
      acc_flag_q  <= acc_flag_d;
      acc_cnt_q   <= acc_cnt_d;
      perform_q   <= perform_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      hits_q      <= hits_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign PERFORM      = perform_q;
  assign BUSY         = busy_q;
  assign RESULT       = result_q;
  assign HITS         = hits_q;
  assign RESULT_VALID = valid_q;
  assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_adc_window_scheduler.sv
// Directed bench for adc_window_scheduler: short windows (8/4) on the main
// instance, a 600-cycle window instance for count saturation.
module tb_adc_window_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, stop, ack;
  logic [7:0]  windows, max_in;
  logic        perform, valid, busy, overrun;
  logic [7:0]  result;
  logic [63:0] hits;

  logic        start_s;
  logic [7:0]  max_in_s;
  logic        s_perform, s_valid, s_busy, s_overrun;
  logic [7:0]  s_result;
  logic [63:0] s_hits;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_window_scheduler #(.WINDOW_CYCLES(8), .GAP_CYCLES(4)) u_dut (
    .CLK(clk), .RST(rst), .START(start), .STOP(stop), .WINDOWS(windows),
    .MAX_IN(max_in), .PERFORM(perform), .RESULT(result), .HITS(hits),
    .RESULT_VALID(valid), .RESULT_ACK(ack), .BUSY(busy), .OVERRUN(overrun)
  );

  adc_window_scheduler #(.WINDOW_CYCLES(600), .GAP_CYCLES(4)) u_sat (
    .CLK(clk), .RST(rst), .START(start_s), .STOP(stop), .WINDOWS(windows),
    .MAX_IN(max_in_s), .PERFORM(s_perform), .RESULT(s_result), .HITS(s_hits),
    .RESULT_VALID(s_valid), .RESULT_ACK(ack), .BUSY(s_busy), .OVERRUN(s_overrun)
  );

  // Advance one clock; outputs are observed 1 ns after the edge.
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; stop = 1'b0; ack = 1'b0; windows = 8'd0; max_in = 8'd0;
    start_s = 1'b0; max_in_s = 8'd0;
    cycle(); cycle();
    rst = 1'b0;
    cycle();
    checks++; if (perform !== 1'b0) begin errors++; $display("FAIL reset_perform got=%0b exp=0", perform); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    checks++; if (hits !== 64'h0) begin errors++; $display("FAIL reset_hits got=%h exp=0", hits); end
  endtask

  task automatic test_single_window();
    int n;
    windows = 8'd1; max_in = 8'h00;
    start = 1'b1; cycle(); start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_rise got=%0b exp=1", busy); end
    n = 0;
    while (perform === 1'b1 && n < 20) begin n++; cycle(); end
    checks++; if (n != 8) begin errors++; $display("FAIL single_perform_len got=%0d exp=8", n); end
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%0b exp=1", valid); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL single_result got=%h exp=00", result); end
    checks++; if (hits !== 64'h0) begin errors++; $display("FAIL single_hits got=%h exp=0", hits); end
    repeat (3) cycle();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_gap got=%0b exp=1", busy); end
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_fall got=%0b exp=0", busy); end
    ack = 1'b1; cycle(); ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_ack got=%0b exp=0", valid); end
  endtask

  task automatic test_flag_accum();
    int n;
    windows = 8'd1;
    max_in = 8'h80;
    start = 1'b1; cycle(); start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      max_in = 8'h80 | ((i == 1 || i == 3 || i == 5) ? 8'h04 : 8'h00);
      cycle();
    end
    max_in = 8'h00;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL accum_valid got=%0b exp=1", valid); end
    checks++; if (result !== 8'h84) begin errors++; $display("FAIL accum_result got=%h exp=84", result); end
    checks++; if (hits !== 64'h0100_0000_0003_0000) begin errors++; $display("FAIL accum_hits got=%h exp=0100000000030000", hits); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL accum_overrun got=%0b exp=0", overrun); end
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; cycle(); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accum_idle_timeout busy=%0b exp=0", busy); end
    ack = 1'b1; cycle(); ack = 1'b0;
  endtask

  task automatic test_saturation();
    int n;
    windows = 8'd1;
    start_s = 1'b1; cycle(); start_s = 1'b0;
    for (int i = 0; i < 600; i++) begin
      max_in_s = (i % 2 == 0) ? 8'h01 : 8'h00;
      cycle();
    end
    max_in_s = 8'h00;
    checks++; if (s_valid !== 1'b1) begin errors++; $display("FAIL sat_valid got=%0b exp=1", s_valid); end
    checks++; if (s_hits[7:0] !== 8'd255) begin errors++; $display("FAIL sat_hits0 got=%0d exp=255", s_hits[7:0]); end
    checks++; if (s_hits[63:8] !== 56'h0) begin errors++; $display("FAIL sat_hits_other got=%h exp=0", s_hits[63:8]); end
    checks++; if (s_result !== 8'h01) begin errors++; $display("FAIL sat_result got=%h exp=01", s_result); end
    n = 0;
    while (s_busy === 1'b1 && n < 50) begin n++; cycle(); end
    checks++; if (s_busy !== 1'b0) begin errors++; $display("FAIL sat_idle_timeout busy=%0b exp=0", s_busy); end
    ack = 1'b1; cycle(); ack = 1'b0;
  endtask

  task automatic test_continuous_stop();
    int pulses, len, fall_c, cyc;
    logic prev_p;
    windows = 8'd0; max_in = 8'h00;
    pulses = 0; len = 0; fall_c = 0; prev_p = 1'b0;
    start = 1'b1; cycle(); start = 1'b0;
    for (cyc = 0; cyc < 200 && busy === 1'b1; cyc++) begin
      if (perform === 1'b1) begin
        if (!prev_p) begin pulses++; len = 0; end
        len++;
      end
      if (perform === 1'b0 && prev_p) begin
        fall_c = cyc;
        checks++; if (len != 8) begin errors++; $display("FAIL cont_len pulse=%0d got=%0d exp=8", pulses, len); end
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL cont_valid pulse=%0d got=%0b exp=1", pulses, valid); end
        if (pulses == 1) begin
          checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL cont_overrun_first got=%0b exp=0", overrun); end
        end
        if (pulses == 2) begin
          checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL cont_overrun_second got=%0b exp=1", overrun); end
        end
      end
      stop = (perform === 1'b1 && pulses == 3 && len == 3);
      prev_p = perform;
      cycle();
    end
    stop = 1'b0;
    checks++; if (pulses != 3) begin errors++; $display("FAIL cont_pulses got=%0d exp=3", pulses); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_busy_end got=%0b exp=0", busy); end
    checks++; if (cyc - fall_c != 4) begin errors++; $display("FAIL cont_busy_fall_delay got=%0d exp=4", cyc - fall_c); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL cont_overrun_sticky got=%0b exp=1", overrun); end
    ack = 1'b1; cycle(); ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL cont_ack got=%0b exp=0", valid); end
  endtask

  task automatic test_handshake();
    int n;
    windows = 8'd2; max_in = 8'h01;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    checks++; if (valid !== 1'b1 || result !== 8'h01) begin errors++; $display("FAIL hs_first valid=%0b result=%h exp=1/01", valid, result); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_start_clears_overrun got=%0b exp=0", overrun); end
    max_in = 8'h10;
    repeat (4) cycle();
    checks++; if (perform !== 1'b1) begin errors++; $display("FAIL hs_second_window got=%0b exp=1", perform); end
    repeat (7) cycle();
    ack = 1'b1; cycle(); ack = 1'b0;
    max_in = 8'h00;
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL hs_publish_wins got=%0b exp=1", valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL hs_no_overrun got=%0b exp=0", overrun); end
    checks++; if (result !== 8'h10) begin errors++; $display("FAIL hs_result got=%h exp=10", result); end
    checks++; if (hits !== 64'h0000_0001_0000_0000) begin errors++; $display("FAIL hs_hits got=%h exp=0000000100000000", hits); end
    n = 0;
    while (busy === 1'b1 && n < 50) begin n++; cycle(); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hs_idle_timeout busy=%0b exp=0", busy); end
    ack = 1'b1; cycle(); ack = 1'b0;
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hs_ack_clear got=%0b exp=0", valid); end
    ack = 1'b1; cycle(); ack = 1'b0;
    checks++; if (valid !== 1'b0 || result !== 8'h10 || overrun !== 1'b0) begin
      errors++; $display("FAIL hs_idle_ack valid=%0b result=%h overrun=%0b exp=0/10/0", valid, result, overrun);
    end
  endtask

  task automatic test_reset_mid();
    windows = 8'd2; max_in = 8'hFF;
    start = 1'b1; cycle(); start = 1'b0;
    repeat (8) cycle();
    checks++; if (valid !== 1'b1 || hits !== 64'h0101_0101_0101_0101) begin
      errors++; $display("FAIL rmid_first valid=%0b hits=%h exp=1/0101010101010101", valid, hits);
    end
    repeat (8) cycle();
    checks++; if (perform !== 1'b1) begin errors++; $display("FAIL rmid_in_window got=%0b exp=1", perform); end
    rst = 1'b1; start = 1'b1;
    cycle();
    checks++; if (perform !== 1'b0) begin errors++; $display("FAIL rmid_perform got=%0b exp=0", perform); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%0b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got=%0b exp=0", valid); end
    checks++; if (hits !== 64'h0 || result !== 8'h00) begin errors++; $display("FAIL rmid_data hits=%h result=%h exp=0/00", hits, result); end
    cycle();
    checks++; if (busy !== 1'b0 || perform !== 1'b0) begin errors++; $display("FAIL rmid_start_ignored busy=%0b perform=%0b exp=0/0", busy, perform); end
    rst = 1'b0; start = 1'b0; max_in = 8'h00;
    cycle();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_after_release got=%0b exp=0", busy); end
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_flag_accum();
    test_saturation();
    test_continuous_stop();
    test_handshake();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "simulation time limit reached");
  end

endmodule
